// File: rtl/regfile_bypass_sb_pkg.sv
// Shared constants and helpers for the bypassing register file and its scoreboard.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_ADDR_W   = 5;
  localparam int unsigned DEF_NUM_REGS = 32;
  localparam int unsigned DEF_NUM_RD   = 2;

  // Upper bound on NUM_REGS accepted by popcount; callers zero-extend into this width.
  localparam int unsigned MAX_REGS = 1024;

  // An index is usable when it addresses an implemented register other than a hardwired zero.
  function automatic logic idx_valid(input int unsigned idx,
                                     input int unsigned num_regs,
                                     input bit          zero_reg);
    return (idx < num_regs) && !(zero_reg && (idx == 32'd0));
  endfunction

  function automatic int unsigned popcount(input logic [MAX_REGS-1:0] vec);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < MAX_REGS; i++) begin
      n += 32'(vec[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_bypass_sb_if.sv
// Decode/writeback bundle of the register file: read ports, writeback, reservation and scoreboard status.
interface regfile_bypass_sb_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned NUM_RD   = DEF_NUM_RD
);

  localparam int unsigned CNT_W = $clog2(NUM_REGS + 1);

  logic [NUM_RD*ADDR_W-1:0] rd_idx;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pend;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_idx;
  logic [DATA_W-1:0]        wr_data;
  logic                     res_en;
  logic [ADDR_W-1:0]        res_idx;
  logic                     flush;
  logic [CNT_W-1:0]         pending_count;
  logic                     any_pending;

  modport master (
    output rd_idx, wr_en, wr_idx, wr_data, res_en, res_idx, flush,
    input  rd_data, rd_pend, pending_count, any_pending
  );

  modport slave (
    input  rd_idx, wr_en, wr_idx, wr_data, res_en, res_idx, flush,
    output rd_data, rd_pend, pending_count, any_pending
  );

endinterface

// File: rtl/regfile_bypass_sb_scoreboard.sv
// Per-register pending bits: flush beats reserve beats writeback release; count tracks the next state.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_en,
  input  logic [ADDR_W-1:0]                  wr_idx,
  input  logic                               res_en,
  input  logic [ADDR_W-1:0]                  res_idx,
  input  logic                               flush,
  output logic [NUM_REGS-1:0]                pending,
  output logic [$clog2(NUM_REGS + 1)-1:0]    pending_count,
  output logic                               any_pending
);

  localparam int unsigned CNT_W = $clog2(NUM_REGS + 1);

  logic [NUM_REGS-1:0] pend_next;
  logic [MAX_REGS-1:0] pend_ext;
  logic                res_ok;

  assign res_ok = res_en && idx_valid(32'(res_idx), NUM_REGS, ZERO_REG != 0);

  always_comb begin
    pend_next = pending;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (flush) begin
        pend_next[i] = 1'b0;
      end else if (res_ok && (res_idx == ADDR_W'(i))) begin
        pend_next[i] = 1'b1;
      end else if (wr_en && (wr_idx == ADDR_W'(i))) begin
        pend_next[i] = 1'b0;
      end
    end
    pend_ext                 = '0;
    pend_ext[NUM_REGS-1:0]   = pend_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending       <= '0;
      pending_count <= '0;
    end else begin
      pending       <= pend_next;
      pending_count <= CNT_W'(popcount(pend_ext));
    end
  end

  assign any_pending = (pending_count != '0);

endmodule

// File: rtl/regfile_bypass_sb.sv
// Multi-port register file with same-cycle write bypass, optional zero register and hazard scoreboard.
module regfile_bypass_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned NUM_RD   = DEF_NUM_RD,
  parameter int unsigned ZERO_REG = 0
) (
  input logic                clk,
  input logic                rst_n,
  regfile_bypass_sb_if.slave bus
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic                wr_ok;

  assign wr_ok = bus.wr_en && idx_valid(32'(bus.wr_idx), NUM_REGS, ZERO_REG != 0);

  // Decoded one-hot write keeps indices beyond NUM_REGS from ever touching the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (bus.wr_idx == ADDR_W'(i)) begin
          regs[i] <= bus.wr_data;
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    logic              valid;
    logic              hit;
    logic [DATA_W-1:0] stored;
    logic              pend;

    assign idx   = bus.rd_idx[p*ADDR_W +: ADDR_W];
    assign valid = idx_valid(32'(idx), NUM_REGS, ZERO_REG != 0);
    assign hit   = bus.wr_en && (bus.wr_idx == idx);

    always_comb begin
      stored = '0;
      pend   = 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (idx == ADDR_W'(i)) begin
          stored = regs[i];
          pend   = pending[i];
        end
      end
    end

    // An invalid index masks both the bypass and the hazard, so a zero register never forwards.
    assign bus.rd_data[p*DATA_W +: DATA_W] = !valid ? '0 : (hit ? bus.wr_data : stored);
    assign bus.rd_pend[p]                  = valid && pend && !hit;
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (bus.wr_en),
    .wr_idx        (bus.wr_idx),
    .res_en        (bus.res_en),
    .res_idx       (bus.res_idx),
    .flush         (bus.flush),
    .pending       (pending),
    .pending_count (bus.pending_count),
    .any_pending   (bus.any_pending)
  );

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Scoreboard-driven bench for regfile_bypass_sb: default, zero-register and wide 3-port instances.
module tb_regfile_bypass_sb;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_bypass_sb_if #(.DATA_W(16), .ADDR_W(5), .NUM_REGS(32), .NUM_RD(2)) bus  ();
  regfile_bypass_sb_if #(.DATA_W(16), .ADDR_W(5), .NUM_REGS(32), .NUM_RD(2)) zbus ();
  regfile_bypass_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(24), .NUM_RD(3)) pbus ();

  regfile_bypass_sb #(.DATA_W(16), .ADDR_W(5), .NUM_REGS(32), .NUM_RD(2), .ZERO_REG(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  regfile_bypass_sb #(.DATA_W(16), .ADDR_W(5), .NUM_REGS(32), .NUM_RD(2), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .bus(zbus));
  regfile_bypass_sb #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(24), .NUM_RD(3), .ZERO_REG(0)) dut_p (
    .clk(clk), .rst_n(rst_n), .bus(pbus));

  int          checks = 0;
  int          passes = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  logic [15:0] mregs [32];
  bit          mpend [32];

  task automatic idle();
    bus.rd_idx  = '0; bus.wr_en  = 1'b0; bus.wr_idx  = '0; bus.wr_data  = '0;
    bus.res_en  = 1'b0; bus.res_idx  = '0; bus.flush  = 1'b0;
    zbus.rd_idx = '0; zbus.wr_en = 1'b0; zbus.wr_idx = '0; zbus.wr_data = '0;
    zbus.res_en = 1'b0; zbus.res_idx = '0; zbus.flush = 1'b0;
    pbus.rd_idx = '0; pbus.wr_en = 1'b0; pbus.wr_idx = '0; pbus.wr_data = '0;
    pbus.res_en = 1'b0; pbus.res_idx = '0; pbus.flush = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); idle();
    bus.wr_en = 1'b1; bus.wr_idx = 5'd5; bus.wr_data = 16'h5555;
    bus.res_en = 1'b1; bus.res_idx = 5'd3;
    @(negedge clk);
    bus.wr_idx = 5'd6; bus.wr_data = 16'h6666; bus.res_idx = 5'd7;
    #2 rst_n = 1'b0;
    @(posedge clk); #1 idle();
    for (int i = 0; i < 32; i++) begin
      bus.rd_idx = {5'(31 - i), 5'(i)};
      exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      #1;
      e = exp_q.pop_front(); checks++;
      if (bus.rd_data[15:0] !== e[15:0]) $display("FAIL reset rd0 idx %0d: got %h want %h", i, bus.rd_data[15:0], e[15:0]); else passes++;
      e = exp_q.pop_front(); checks++;
      if (bus.rd_data[31:16] !== e[15:0]) $display("FAIL reset rd1 idx %0d: got %h want %h", 31 - i, bus.rd_data[31:16], e[15:0]); else passes++;
      e = exp_q.pop_front(); checks++;
      if (bus.rd_pend !== e[1:0]) $display("FAIL reset rd_pend idx %0d: got %b want %b", i, bus.rd_pend, e[1:0]); else passes++;
    end
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); checks++;
    if (bus.pending_count !== e[5:0]) $display("FAIL reset pending_count: got %0d want %0d", bus.pending_count, e[5:0]); else passes++;
    e = exp_q.pop_front(); checks++;
    if (bus.any_pending !== e[0]) $display("FAIL reset any_pending: got %b want %b", bus.any_pending, e[0]); else passes++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge clk); idle();
    bus.wr_en = 1'b1; bus.wr_idx = 5'd5; bus.wr_data = 16'hBEEF;
    @(negedge clk); idle();
    bus.rd_idx = {5'd5, 5'd5};
    exp_q.push_back(32'hBEEF); exp_q.push_back(32'hBEEF);
    #1;
    e = exp_q.pop_front(); checks++;
    if (bus.rd_data[15:0] !== e[15:0]) $display("FAIL write_read rd0 r5: got %h want %h", bus.rd_data[15:0], e[15:0]); else passes++;
    e = exp_q.pop_front(); checks++;
    if (bus.rd_data[31:16] !== e[15:0]) $display("FAIL write_read rd1 r5: got %h want %h", bus.rd_data[31:16], e[15:0]); else passes++;
  endtask

  task automatic test_bypass();
    @(negedge clk); idle();
    bus.wr_en = 1'b1; bus.wr_idx = 5'd7; bus.wr_data = 16'h1234;
    bus.rd_idx = {5'd7, 5'd6};
    exp_q.push_back(32'h1234); exp_q.push_back(32'h0000);
    #1;
    e = exp_q.pop_front(); checks++;
    if (bus.rd_data[31:16] !== e[15:0]) $display("FAIL bypass rd1 r7: got %h want %h", bus.rd_data[31:16], e[15:0]); else passes++;
    e = exp_q.pop_front(); checks++;
    if (bus.rd_data[15:0] !== e[15:0]) $display("FAIL bypass rd0 r6: got %h want %h", bus.rd_data[15:0], e[15:0]); else passes++;
    @(negedge clk); idle();
    bus.rd_idx = {5'd0, 5'd7};
    exp_q.push_back(32'h1234);
    #1;
    e = exp_q.pop_front(); checks++;
    if (bus.rd_data[15:0] !== e[15:0]) $display("FAIL bypass stored r7: got %h want %h", bus.rd_data[15:0], e[15:0]); else passes++;
  endtask

  task automatic test_zero_reg();
    @(negedge clk); idle();
    bus.wr_en  = 1'b1; bus.wr_idx  = 5'd0; bus.wr_data  = 16'hFFFF; bus.res_en  = 1'b1; bus.res_idx  = 5'd0;
    zbus.wr_en = 1'b1; zbus.wr_idx = 5'd0; zbus.wr_data = 16'hFFFF; zbus.res_en = 1'b1; zbus.res_idx = 5'd0;
    exp_q.push_back(32'h0000); exp_q.push_back(32'hFFFF);
    #1;
    e = exp_q.pop_front(); checks++;
    if (zbus.rd_data[15:0] !== e[15:0]) $display("FAIL zero no_bypass r0: got %h want %h", zbus.rd_data[15:0], e[15:0]); else passes++;
    e = exp_q.pop_front(); checks++;
    if (bus.rd_data[15:0] !== e[15:0]) $display("FAIL nozero bypass r0: got %h want %h", bus.rd_data[15:0], e[15:0]); else passes++;
    @(negedge clk); idle();
    exp_q.push_back(32'h0000); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'hFFFF); exp_q.push_back(32'h1); exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); checks++;
    if (zbus.rd_data[15:0] !== e[15:0]) $display("FAIL zero read r0: got %h want %h", zbus.rd_data[15:0], e[15:0]); else passes++;
    e = exp_q.pop_front(); checks++;
    if (zbus.rd_pend[0] !== e[0]) $display("FAIL zero rd_pend r0: got %b want %b", zbus.rd_pend[0], e[0]); else passes++;
    e = exp_q.pop_front(); checks++;
    if (zbus.pending_count !== e[5:0]) $display("FAIL zero pending_count: got %0d want %0d", zbus.pending_count, e[5:0]); else passes++;
    e = exp_q.pop_front(); checks++;
    if (bus.rd_data[15:0] !== e[15:0]) $display("FAIL nozero read r0: got %h want %h", bus.rd_data[15:0], e[15:0]); else passes++;
    e = exp_q.pop_front(); checks++;
    if (bus.rd_pend[0] !== e[0]) $display("FAIL nozero rd_pend r0: got %b want %b", bus.rd_pend[0], e[0]); else passes++;
    e = exp_q.pop_front(); checks++;
    if (bus.pending_count !== e[5:0]) $display("FAIL nozero pending_count: got %0d want %0d", bus.pending_count, e[5:0]); else passes++;
    @(negedge clk); idle();
    bus.wr_en = 1'b1; bus.wr_idx = 5'd0; bus.wr_data = 16'hFFFF;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (bus.rd_pend[0] !== e[0]) $display("FAIL nozero release rd_pend: got %b want %b", bus.rd_pend[0], e[0]); else passes++;
    @(posedge clk); #1;
    e = exp_q.pop_front(); checks++;
    if (bus.pending_count !== e[5:0]) $display("FAIL nozero release count: got %0d want %0d", bus.pending_count, e[5:0]); else passes++;
  endtask

  task automatic test_scoreboard();
    @(negedge clk); idle(); bus.res_en = 1'b1; bus.res_idx = 5'd3;
    @(negedge clk); bus.res_idx = 5'd9;
    @(negedge clk); idle(); bus.rd_idx = {5'd9, 5'd3};
    exp_q.push_back(32'd2); exp_q.push_back(32'h1); exp_q.push_back(32'h3);
    #1;
    e = exp_q.pop_front(); checks++;
    if (bus.pending_count !== e[5:0]) $display("FAIL sb count two: got %0d want %0d", bus.pending_count, e[5:0]); else passes++;
    e = exp_q.pop_front(); checks++;
    if (bus.any_pending !== e[0]) $display("FAIL sb any_pending: got %b want %b", bus.any_pending, e[0]); else passes++;
    e = exp_q.pop_front(); checks++;
    if (bus.rd_pend !== e[1:0]) $display("FAIL sb rd_pend r3 r9: got %b want %b", bus.rd_pend, e[1:0]); else passes++;
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_idx = 5'd3; bus.wr_data = 16'h0333;
    exp_q.push_back(32'h2); exp_q.push_back(32'h0333); exp_q.push_back(32'd1);
    #1;
    e = exp_q.pop_front(); checks++;
    if (bus.rd_pend !== e[1:0]) $display("FAIL sb write r3 rd_pend: got %b want %b", bus.rd_pend, e[1:0]); else passes++;
    e = exp_q.pop_front(); checks++;
    if (bus.rd_data[15:0] !== e[15:0]) $display("FAIL sb write r3 data: got %h want %h", bus.rd_data[15:0], e[15:0]); else passes++;
    @(posedge clk); #1;
    e = exp_q.pop_front(); checks++;
    if (bus.pending_count !== e[5:0]) $display("FAIL sb count after r3: got %0d want %0d", bus.pending_count, e[5:0]); else passes++;
    @(negedge clk); idle();
    bus.res_en = 1'b1; bus.res_idx = 5'd9; bus.wr_en = 1'b1; bus.wr_idx = 5'd9; bus.wr_data = 16'h0999;
    bus.rd_idx = {5'd9, 5'd9};
    exp_q.push_back(32'h0); exp_q.push_back(32'h0999); exp_q.push_back(32'd1);
    #1;
    e = exp_q.pop_front(); checks++;
    if (bus.rd_pend !== e[1:0]) $display("FAIL sb res+wr r9 rd_pend: got %b want %b", bus.rd_pend, e[1:0]); else passes++;
    e = exp_q.pop_front(); checks++;
    if (bus.rd_data[31:16] !== e[15:0]) $display("FAIL sb res+wr r9 data: got %h want %h", bus.rd_data[31:16], e[15:0]); else passes++;
    @(posedge clk); #1;
    e = exp_q.pop_front(); checks++;
    if (bus.pending_count !== e[5:0]) $display("FAIL sb count res+wr: got %0d want %0d", bus.pending_count, e[5:0]); else passes++;
    @(negedge clk); idle(); bus.rd_idx = {5'd9, 5'd9};
    exp_q.push_back(32'h3); exp_q.push_back(32'h0999);
    #1;
    e = exp_q.pop_front(); checks++;
    if (bus.rd_pend !== e[1:0]) $display("FAIL sb r9 still pending: got %b want %b", bus.rd_pend, e[1:0]); else passes++;
    e = exp_q.pop_front(); checks++;
    if (bus.rd_data[15:0] !== e[15:0]) $display("FAIL sb r9 stored: got %h want %h", bus.rd_data[15:0], e[15:0]); else passes++;
    @(negedge clk); idle(); bus.wr_en = 1'b1; bus.wr_idx = 5'd12; bus.wr_data = 16'h0C0C;
    exp_q.push_back(32'd1);
    @(posedge clk); #1;
    e = exp_q.pop_front(); checks++;
    if (bus.pending_count !== e[5:0]) $display("FAIL sb write unpending: got %0d want %0d", bus.pending_count, e[5:0]); else passes++;
    @(negedge clk); idle(); bus.wr_en = 1'b1; bus.wr_idx = 5'd9;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    @(posedge clk); #1;
    e = exp_q.pop_front(); checks++;
    if (bus.pending_count !== e[5:0]) $display("FAIL sb release r9 count: got %0d want %0d", bus.pending_count, e[5:0]); else passes++;
    e = exp_q.pop_front(); checks++;
    if (bus.any_pending !== e[0]) $display("FAIL sb release any: got %b want %b", bus.any_pending, e[0]); else passes++;
  endtask

  task automatic test_flush();
    @(negedge clk); idle(); bus.res_en = 1'b1; bus.res_idx = 5'd1;
    @(negedge clk); bus.res_idx = 5'd2;
    @(negedge clk); bus.res_idx = 5'd4;
    exp_q.push_back(32'd3);
    @(posedge clk); #1;
    e = exp_q.pop_front(); checks++;
    if (bus.pending_count !== e[5:0]) $display("FAIL flush pre count: got %0d want %0d", bus.pending_count, e[5:0]); else passes++;
    @(negedge clk); bus.flush = 1'b1; bus.res_idx = 5'd8;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'h0);
    @(posedge clk); #1;
    e = exp_q.pop_front(); checks++;
    if (bus.pending_count !== e[5:0]) $display("FAIL flush count: got %0d want %0d", bus.pending_count, e[5:0]); else passes++;
    e = exp_q.pop_front(); checks++;
    if (bus.any_pending !== e[0]) $display("FAIL flush any: got %b want %b", bus.any_pending, e[0]); else passes++;
    @(negedge clk); idle(); bus.rd_idx = {5'd1, 5'd8};
    #1;
    e = exp_q.pop_front(); checks++;
    if (bus.rd_pend !== e[1:0]) $display("FAIL flush rd_pend r8 r1: got %b want %b", bus.rd_pend, e[1:0]); else passes++;
  endtask

  task automatic test_params();
    @(negedge clk); idle();
    pbus.wr_en = 1'b1; pbus.wr_idx = 5'd30; pbus.wr_data = 32'hDEADBEEF;
    pbus.rd_idx = {5'd30, 5'd30, 5'd30};
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (pbus.rd_data[31:0] !== e) $display("FAIL param idx30 no bypass: got %h want %h", pbus.rd_data[31:0], e); else passes++;
    @(negedge clk); idle(); pbus.rd_idx = {5'd30, 5'd30, 5'd30};
    pbus.wr_en = 1'b1; pbus.wr_idx = 5'd10; pbus.wr_data = 32'hCAFEF00D;
    #1;
    for (int p = 0; p < 3; p++) begin
      exp_q.push_back(32'h0);
      e = exp_q.pop_front(); checks++;
      if (pbus.rd_data[p*32 +: 32] !== e) $display("FAIL param idx30 port %0d: got %h want %h", p, pbus.rd_data[p*32 +: 32], e); else passes++;
    end
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); checks++;
    if (pbus.rd_pend !== e[2:0]) $display("FAIL param idx30 rd_pend: got %b want %b", pbus.rd_pend, e[2:0]); else passes++;
    @(negedge clk); idle(); pbus.rd_idx = {5'd10, 5'd10, 5'd10};
    pbus.wr_en = 1'b1; pbus.wr_idx = 5'd23; pbus.wr_data = 32'h23232323;
    pbus.res_en = 1'b1; pbus.res_idx = 5'd30;
    #1;
    for (int p = 0; p < 3; p++) begin
      exp_q.push_back(32'hCAFEF00D);
      e = exp_q.pop_front(); checks++;
      if (pbus.rd_data[p*32 +: 32] !== e) $display("FAIL param r10 port %0d: got %h want %h", p, pbus.rd_data[p*32 +: 32], e); else passes++;
    end
    exp_q.push_back(32'd0);
    @(posedge clk); #1;
    e = exp_q.pop_front(); checks++;
    if (pbus.pending_count !== e[4:0]) $display("FAIL param reserve idx30 count: got %0d want %0d", pbus.pending_count, e[4:0]); else passes++;
    @(negedge clk); idle(); pbus.wr_en = 1'b1; pbus.wr_idx = 5'd24; pbus.wr_data = 32'h24242424;
    @(negedge clk); idle(); pbus.rd_idx = {5'd10, 5'd24, 5'd23};
    exp_q.push_back(32'h23232323); exp_q.push_back(32'h0); exp_q.push_back(32'hCAFEF00D);
    #1;
    for (int p = 0; p < 3; p++) begin
      e = exp_q.pop_front(); checks++;
      if (pbus.rd_data[p*32 +: 32] !== e) $display("FAIL param edge port %0d: got %h want %h", p, pbus.rd_data[p*32 +: 32], e); else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  widx, ridx, r0, r1;
    logic [15:0] wd;
    bit          we, re, fl;
    int unsigned cnt;
    @(negedge clk); idle(); rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      mregs[i] = '0;
      mpend[i] = 1'b0;
    end
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      we   = ($urandom_range(0, 3) != 0);
      widx = 5'($urandom_range(0, 31));
      wd   = 16'($urandom);
      re   = ($urandom_range(0, 2) == 0);
      ridx = 5'($urandom_range(0, 31));
      fl   = ($urandom_range(0, 24) == 0);
      r0   = 5'($urandom_range(0, 31));
      r1   = ($urandom_range(0, 3) == 0) ? widx : 5'($urandom_range(0, 31));
      bus.wr_en = we; bus.wr_idx = widx; bus.wr_data = wd;
      bus.res_en = re; bus.res_idx = ridx; bus.flush = fl;
      bus.rd_idx = {r1, r0};
      exp_q.push_back({16'h0, (we && widx == r0) ? wd : mregs[r0]});
      exp_q.push_back({16'h0, (we && widx == r1) ? wd : mregs[r1]});
      exp_q.push_back({30'h0, mpend[r1] && !(we && widx == r1), mpend[r0] && !(we && widx == r0)});
      if (we) mregs[widx] = wd;
      if (fl) begin
        for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
      end else begin
        if (we) mpend[widx] = 1'b0;
        if (re) mpend[ridx] = 1'b1;
      end
      cnt = 0;
      for (int i = 0; i < 32; i++) cnt += 32'(mpend[i]);
      exp_q.push_back(cnt);
      #1;
      e = exp_q.pop_front(); checks++;
      if (bus.rd_data[15:0] !== e[15:0]) $display("FAIL b2b rd0 cyc %0d: got %h want %h", n, bus.rd_data[15:0], e[15:0]); else passes++;
      e = exp_q.pop_front(); checks++;
      if (bus.rd_data[31:16] !== e[15:0]) $display("FAIL b2b rd1 cyc %0d: got %h want %h", n, bus.rd_data[31:16], e[15:0]); else passes++;
      e = exp_q.pop_front(); checks++;
      if (bus.rd_pend !== e[1:0]) $display("FAIL b2b rd_pend cyc %0d: got %b want %b", n, bus.rd_pend, e[1:0]); else passes++;
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      if (bus.pending_count !== e[5:0]) $display("FAIL b2b count cyc %0d: got %0d want %0d", n, bus.pending_count, e[5:0]); else passes++;
    end
    @(negedge clk); idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_flush();
    test_params();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
